// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer sitting in front of the instruction ROM.
// It owns the program counter, registers the ROM word into an instruction
// register and offers it downstream over a valid/ready handshake. It also
// provides start, abort, loop-wrap and halt-word control.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             begin a run (honoured only in IDLE or DONE)
//   abort             cancel the run and return to IDLE
//   loop_en           wrap LAST_ADDR -> START_ADDR instead of finishing
//   addr_ROM          ROM address, driven directly from pc
//   d_ROM             combinational ROM data for addr_ROM
//   instr/instr_valid registered instruction and its valid flag
//   instr_ready       downstream accepts instr on this edge
//   pc                program counter
//   busy/done         run in progress / run completed
//   fetch_cnt         saturating count of transfers in the current run
module fetch_seq #(
    parameter int unsigned       ADDR_W     = 4,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(15),
    parameter logic [DATA_W-1:0] HALT_CODE  = DATA_W'(32'hFFFF_FFFF),
    parameter int unsigned       CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] addr_ROM,
    input  logic [DATA_W-1:0] d_ROM,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fetch_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fetch_cnt_q   <= fetch_cnt_d;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        busy_d        = busy_q;
        done_d        = done_q;
        fetch_cnt_d   = fetch_cnt_q;

        // abort outranks start and the handshake; pc, instr and count are kept
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            instr_valid_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_FETCH;
                        pc_d        = START_ADDR;
                        fetch_cnt_d = '0;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                    end
                end
                S_FETCH: begin
                    instr_d       = d_ROM;
                    instr_valid_d = 1'b1;
                    state_d       = S_VALID;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        if (fetch_cnt_q != CNT_MAX) begin
                            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                        end
                        if (instr_q == HALT_CODE) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (pc_q == LAST_ADDR) begin
                            if (loop_en) begin
                                pc_d    = START_ADDR;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            pc_d    = pc_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign addr_ROM    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: a behavioural ROM plus a program-walk reference
// model that lists the expected (pc, word) transfer sequence for a run.
module tb_fetch_seq;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, start, abort, loop_en, instr_ready;
    logic [3:0]  addr_ROM, pc;
    logic [31:0] d_ROM, instr;
    logic        instr_valid, busy, done;
    logic [7:0]  fetch_cnt;

    logic [31:0] rom [16];
    assign d_ROM = rom[addr_ROM];

    fetch_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
        .addr_ROM(addr_ROM), .d_ROM(d_ROM), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .busy(busy), .done(done), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // observed transfers and the model's expected transfers
    logic [31:0] obs_w[$];
    logic [3:0]  obs_pc[$];
    int          obs_cnt[$];
    int          obs_gap[$];
    int          hold_bad;
    int          stall_cycles;
    logic [31:0] exp_w[$];
    logic [3:0]  exp_pc[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom();
        int vals [16] = '{4, 4, 5, 5, 6, 6, 7, 8, 9, 10, 11, 12, 13, 14, 0, 1};
        for (int i = 0; i < 16; i++) rom[i] = 32'(vals[i]);
    endtask

    // Reference model: walk the program from address 0 following the run rules.
    task automatic build_exp(input bit lp, input int max_n);
        int a;
        a = 0;
        exp_w.delete();
        exp_pc.delete();
        while (exp_w.size() < max_n) begin
            exp_w.push_back(rom[a]);
            exp_pc.push_back(4'(a));
            if (rom[a] == HALT) break;
            if (a == 15) begin
                if (!lp) break;
                a = 0;
            end else begin
                a = a + 1;
            end
        end
    endtask

    // Drive instr_ready for max_cycles and record every transfer.
    // mode 0: ready always 1; 1: random; 2: random plus a 5-cycle stall at pc 3.
    task automatic collect(input int max_cycles, input int mode);
        int          last;
        int          stall;
        bit          held;
        logic [31:0] h_w;
        logic [3:0]  h_pc;
        last = -1; stall = 0; held = 0; h_w = '0; h_pc = '0;
        obs_w.delete(); obs_pc.delete(); obs_cnt.delete(); obs_gap.delete();
        hold_bad = 0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (instr_valid) begin
                if (held) begin
                    if (instr !== h_w || pc !== h_pc) hold_bad++;
                end else begin
                    obs_gap.push_back(cyc - last);
                    last = cyc;
                end
            end
            case (mode)
                0: instr_ready = 1'b1;
                1: instr_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (instr_valid && pc == 4'd3 && stall < 5) begin
                        instr_ready = 1'b0;
                        stall++;
                    end else begin
                        instr_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            endcase
            if (instr_valid && instr_ready) begin
                obs_w.push_back(instr);
                obs_pc.push_back(pc);
                obs_cnt.push_back(int'(fetch_cnt));
            end
            held = instr_valid && !instr_ready;
            h_w  = instr;
            h_pc = pc;
            step();
        end
        stall_cycles = stall;
        instr_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic test_reset();
        start = 0; abort = 0; loop_en = 0; instr_ready = 0;
        do_reset();
        n_vec++; if (pc !== 4'd0)      begin n_err++; $display("FAIL reset_pc got %0h exp 0", pc); end
        n_vec++; if (addr_ROM !== 4'd0) begin n_err++; $display("FAIL reset_addr got %0h exp 0", addr_ROM); end
        n_vec++; if (instr !== 32'd0)  begin n_err++; $display("FAIL reset_instr got %0h exp 0", instr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
        n_vec++; if (fetch_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", fetch_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        loop_en = 0;
        build_exp(1'b0, 100);
        pulse_start();
        collect(45, 0);
        n_vec++; if (obs_w.size() != exp_w.size()) begin n_err++; $display("FAIL basic_count got %0d exp %0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            n_vec++;
            if (obs_w[i] !== exp_w[i] || obs_pc[i] !== exp_pc[i] || obs_cnt[i] != i) begin
                n_err++;
                $display("FAIL basic_xfer[%0d] got w=%0h pc=%0d cnt=%0d exp w=%0h pc=%0d cnt=%0d",
                         i, obs_w[i], obs_pc[i], obs_cnt[i], exp_w[i], exp_pc[i], i);
            end
        end
        for (int i = 0; i < obs_gap.size(); i++) begin
            n_vec++; if (obs_gap[i] != 2) begin n_err++; $display("FAIL basic_spacing[%0d] got %0d exp 2", i, obs_gap[i]); end
        end
        n_vec++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL basic_done got busy,done=%b exp 01", {busy, done}); end
        n_vec++; if (pc !== 4'd15) begin n_err++; $display("FAIL basic_pc got %0d exp 15", pc); end
        n_vec++; if (fetch_cnt !== 8'd16) begin n_err++; $display("FAIL basic_cnt got %0d exp 16", fetch_cnt); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid got %0b exp 0", instr_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        loop_en = 0;
        build_exp(1'b0, 100);
        pulse_start();
        collect(200, 2);
        n_vec++; if (obs_w.size() != exp_w.size()) begin n_err++; $display("FAIL bp_count got %0d exp %0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            n_vec++;
            if (obs_w[i] !== exp_w[i] || obs_pc[i] !== exp_pc[i] || obs_cnt[i] != i) begin
                n_err++;
                $display("FAIL bp_xfer[%0d] got w=%0h pc=%0d cnt=%0d exp w=%0h pc=%0d cnt=%0d",
                         i, obs_w[i], obs_pc[i], obs_cnt[i], exp_w[i], exp_pc[i], i);
            end
        end
        n_vec++; if (stall_cycles != 5) begin n_err++; $display("FAIL bp_stall got %0d exp 5", stall_cycles); end
        n_vec++; if (hold_bad != 0) begin n_err++; $display("FAIL bp_hold_stable got %0d exp 0", hold_bad); end
        n_vec++; if ({busy, done, fetch_cnt} !== {2'b01, 8'd16}) begin n_err++; $display("FAIL bp_end got busy,done,cnt=%b/%0d exp 01/16", {busy, done}, fetch_cnt); end
    endtask

    task automatic test_loop();
        do_reset();
        loop_en = 1;
        build_exp(1'b1, 20);
        pulse_start();
        collect(40, 0);
        n_vec++; if (obs_w.size() != 20) begin n_err++; $display("FAIL loop_count got %0d exp 20", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            n_vec++;
            if (obs_w[i] !== exp_w[i] || obs_pc[i] !== exp_pc[i] || obs_cnt[i] != i) begin
                n_err++;
                $display("FAIL loop_xfer[%0d] got w=%0h pc=%0d cnt=%0d exp w=%0h pc=%0d cnt=%0d",
                         i, obs_w[i], obs_pc[i], obs_cnt[i], exp_w[i], exp_pc[i], i);
            end
        end
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL loop_busy got busy,done=%b exp 10", {busy, done}); end
        abort = 1; step(); abort = 0;
        loop_en = 0;
        n_vec++; if ({busy, done, instr_valid} !== 3'b000) begin n_err++; $display("FAIL loop_abort got %b exp 000", {busy, done, instr_valid}); end
    endtask

    task automatic test_halt();
        rom[5] = HALT;
        do_reset();
        loop_en = 0;
        build_exp(1'b0, 100);
        pulse_start();
        collect(120, 1);
        n_vec++; if (obs_w.size() != 6) begin n_err++; $display("FAIL halt_count got %0d exp 6", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            n_vec++;
            if (obs_w[i] !== exp_w[i] || obs_pc[i] !== exp_pc[i]) begin
                n_err++;
                $display("FAIL halt_xfer[%0d] got w=%0h pc=%0d exp w=%0h pc=%0d", i, obs_w[i], obs_pc[i], exp_w[i], exp_pc[i]);
            end
        end
        n_vec++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL halt_done got busy,done=%b exp 01", {busy, done}); end
        n_vec++; if (pc !== 4'd5) begin n_err++; $display("FAIL halt_pc got %0d exp 5", pc); end
        n_vec++; if (fetch_cnt !== 8'd6) begin n_err++; $display("FAIL halt_cnt got %0d exp 6", fetch_cnt); end
        // start and abort together in DONE: abort wins
        start = 1; abort = 1; step(); start = 0; abort = 0;
        n_vec++; if ({busy, done, instr_valid} !== 3'b000) begin n_err++; $display("FAIL done_abort got %b exp 000", {busy, done, instr_valid}); end
        n_vec++; if (pc !== 4'd5) begin n_err++; $display("FAIL done_abort_pc got %0d exp 5", pc); end
        step(); step();
        n_vec++; if ({busy, instr_valid} !== 2'b00) begin n_err++; $display("FAIL done_abort_idle got %b exp 00", {busy, instr_valid}); end
        load_rom();
    endtask

    task automatic test_abort();
        int  k;
        bit  found;
        do_reset();
        loop_en = 0;
        pulse_start();
        found = 0;
        instr_ready = 1;
        for (k = 0; k < 100 && !found; k++) begin
            if (instr_valid && pc == 4'd7) found = 1;
            else step();
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL abort_wait got timeout exp valid at pc 7"); end
        abort = 1; instr_ready = 1; step(); abort = 0; instr_ready = 0;
        n_vec++; if ({busy, done, instr_valid} !== 3'b000) begin n_err++; $display("FAIL abort_state got %b exp 000", {busy, done, instr_valid}); end
        n_vec++; if (pc !== 4'd7) begin n_err++; $display("FAIL abort_pc got %0d exp 7", pc); end
        n_vec++; if (fetch_cnt !== 8'd7) begin n_err++; $display("FAIL abort_cnt got %0d exp 7", fetch_cnt); end
        n_vec++; if (instr !== 32'd8) begin n_err++; $display("FAIL abort_instr got %0h exp 8", instr); end
        // restart; start is then held high while busy and must be ignored
        start = 1; step();
        n_vec++; if ({pc, fetch_cnt, busy} !== {4'd0, 8'd0, 1'b1}) begin n_err++; $display("FAIL restart got pc=%0d cnt=%0d busy=%0b exp 0/0/1", pc, fetch_cnt, busy); end
        build_exp(1'b0, 100);
        collect(12, 0);
        start = 0;
        n_vec++; if (obs_w.size() != 6) begin n_err++; $display("FAIL busy_start_count got %0d exp 6", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            n_vec++;
            if (obs_w[i] !== exp_w[i] || obs_pc[i] !== exp_pc[i] || obs_cnt[i] != i) begin
                n_err++;
                $display("FAIL busy_start_xfer[%0d] got w=%0h pc=%0d cnt=%0d exp w=%0h pc=%0d cnt=%0d",
                         i, obs_w[i], obs_pc[i], obs_cnt[i], exp_w[i], exp_pc[i], i);
            end
        end
        // synchronous reset mid-run
        rst = 1; step(); rst = 0;
        n_vec++; if ({pc, addr_ROM, instr, instr_valid, busy, done, fetch_cnt} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset got pc=%0d addr=%0d instr=%0h v=%0b busy=%0b done=%0b cnt=%0d exp all 0",
                     pc, addr_ROM, instr, instr_valid, busy, done, fetch_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        loop_en = 1;
        build_exp(1'b1, 270);
        pulse_start();
        collect(540, 0);
        n_vec++; if (obs_w.size() != 270) begin n_err++; $display("FAIL sat_count got %0d exp 270", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            n_vec++;
            if (obs_w[i] !== exp_w[i] || obs_cnt[i] != ((i > 255) ? 255 : i)) begin
                n_err++;
                $display("FAIL sat_xfer[%0d] got w=%0h cnt=%0d exp w=%0h cnt=%0d",
                         i, obs_w[i], obs_cnt[i], exp_w[i], (i > 255) ? 255 : i);
            end
        end
        n_vec++; if (fetch_cnt !== 8'd255) begin n_err++; $display("FAIL sat_final got %0d exp 255", fetch_cnt); end
        loop_en = 0;
        abort = 1; step(); abort = 0;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; loop_en = 0; instr_ready = 0;
        load_rom();
        test_reset();
        test_basic();
        test_backpressure();
        test_loop();
        test_halt();
        test_abort();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
